// File: rtl/muldiv_sequencer_if.sv
// Handshake and operand bundle between decode/writeback and the multiply sequencer.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [3:0]      aluop;
  logic            flush;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, aluop, flush, a, b,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, aluop, flush, a, b,
    output stall, busy, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Radix-2 shift-add sequencer for mul/mulh/mulhu; one iteration per clock.
// Optional macro MULDIV_EARLY_EXIT_EN ends RUN as soon as the multiplier empties.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MULH  = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;

  localparam int CW = $clog2(XLEN) + 1;

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [3:0]        op;
  logic              neg;
  logic [XLEN-1:0]   result_q;

  logic              op_valid;
  logic              accept;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   mplier_next;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   result_next;
  logic              last_iter;

  always_comb begin
    op_valid    = (bus.aluop == OP_MUL) || (bus.aluop == OP_MULH) || (bus.aluop == OP_MULHU);
    accept      = (state == IDLE) && bus.start && !bus.flush && op_valid;
    // Unsigned magnitudes; 0x80000000 negates to itself, i.e. 2^31 unsigned.
    a_mag       = bus.a[XLEN-1] ? (~bus.a + 1'b1) : bus.a;
    b_mag       = bus.b[XLEN-1] ? (~bus.b + 1'b1) : bus.b;
    acc_next    = mplier[0] ? (acc + mcand) : acc;
    mplier_next = mplier >> 1;
    product     = neg ? (~acc_next + 1'b1) : acc_next;
    result_next = (op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
`ifdef MULDIV_EARLY_EXIT_EN
    last_iter   = (count == CW'(XLEN - 1)) || (mplier_next == '0);
`else
    last_iter   = (count == CW'(XLEN - 1));
`endif
  end

  assign bus.stall  = accept || (state == RUN);
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

  // The multiplicand shifts left each iteration, equivalent to adding it shifted by count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      op       <= '0;
      neg      <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op    <= bus.aluop;
            acc   <= '0;
            count <= '0;
            if (bus.aluop == OP_MULH) begin
              mcand  <= {{XLEN{1'b0}}, a_mag};
              mplier <= b_mag;
              neg    <= bus.a[XLEN-1] ^ bus.b[XLEN-1];
            end else begin
              mcand  <= {{XLEN{1'b0}}, bus.a};
              mplier <= bus.b;
              neg    <= 1'b0;
            end
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier_next;
            count  <= count + CW'(1);
            if (last_iter) begin
              state    <= DONE;
              result_q <= result_next;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; expected products are hand-computed.
// Latency expectations follow MULDIV_EARLY_EXIT_EN when it is defined.
module tb_muldiv_sequencer;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MULH  = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;
  localparam logic [3:0] OP_ADD   = 4'b0011;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 2 units after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic st, input logic [3:0] op, input logic [31:0] av,
                                input logic [31:0] bv, input logic fl);
    bus.start = st;
    bus.aluop = op;
    bus.a     = av;
    bus.b     = bv;
    bus.flush = fl;
    #1;
  endtask

  function automatic int expected_latency(input logic [3:0] op, input logic [31:0] bv);
`ifdef MULDIV_EARLY_EXIT_EN
    logic [31:0] m;
    int          n;
    m = (op == OP_MULH && bv[31]) ? (~bv + 32'd1) : bv;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n + 1;
`else
    return 33;
`endif
  endfunction

  // Starts an op in IDLE, waits for done with a bound, checks latency, stall and result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_result);
    int lat;
    apply_stimulus(1'b1, op, av, bv, 1'b0);
    check_output({tag, "_stall_T"}, 32'(bus.stall), 32'd1);
    tick();
    apply_stimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
    lat = 1;
    while (!bus.done && lat < 40) begin
      tick();
      #1;
      lat++;
    end
    check_output({tag, "_done"}, 32'(bus.done), 32'd1);
    check_output({tag, "_latency"}, 32'(lat), 32'(expected_latency(op, bv)));
    check_output({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
    check_output({tag, "_result"}, bus.result, exp_result);
    tick();
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.start = 1'b0;
    bus.aluop = 4'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.flush = 1'b0;
    rst = 1'b1;
    #12;
    check_output("reset_busy", 32'(bus.busy), 32'd0);
    check_output("reset_done", 32'(bus.done), 32'd0);
    check_output("reset_stall", 32'(bus.stall), 32'd0);
    check_output("reset_result", bus.result, 32'd0);
    rst = 1'b0;
    tick();

    // mul 7*6 with cycle-by-cycle stall/done tracking over the full run
    apply_stimulus(1'b1, OP_MUL, 32'd7, 32'd6, 1'b0);
    check_output("t1_stall_T", 32'(bus.stall), 32'd1);
    check_output("t1_busy_T", 32'(bus.busy), 32'd0);
    tick();
    apply_stimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
    for (int k = 1; k < expected_latency(OP_MUL, 32'd6); k++) begin
      checks++;
      assert (bus.stall === 1'b1 && bus.done === 1'b0 && bus.busy === 1'b1)
      else begin
        errors++;
        $error("[TB] FAIL t1_run_cycle%0d observed stall=%b done=%b busy=%b expected 1/0/1",
               k, bus.stall, bus.done, bus.busy);
      end
      tick();
      #1;
    end
    check_output("t1_done", 32'(bus.done), 32'd1);
    check_output("t1_stall_done", 32'(bus.stall), 32'd0);
    check_output("t1_result", bus.result, 32'h0000002A);
    // start in the DONE cycle must be ignored
    apply_stimulus(1'b1, OP_MUL, 32'd9, 32'd9, 1'b0);
    tick();
    apply_stimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
    check_output("t1_busy_after", 32'(bus.busy), 32'd0);
    check_output("t1_done_after", 32'(bus.done), 32'd0);
    check_output("t1_result_hold", bus.result, 32'h0000002A);

    run_op("mulh_neg", OP_MULH, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);
    run_op("mul_neg", OP_MUL, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA);
    run_op("mulhu_max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulh_min", OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op("mul_max", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run_op("mulhu_2p31", OP_MULHU, 32'h80000000, 32'h00000002, 32'h00000001);
    run_op("mulh_pos_neg", OP_MULH, 32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF);
    run_op("mul_zero", OP_MUL, 32'd5, 32'd0, 32'd0);
    run_op("mul_one", OP_MUL, 32'd12345, 32'd1, 32'd12345);
    run_op("mul_5x3", OP_MUL, 32'd5, 32'd3, 32'h0000000F);

    // asynchronous reset in the middle of a long run
    apply_stimulus(1'b1, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    tick();
    apply_stimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
    repeat (9) tick();
    check_output("t4_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_output("t4_busy", 32'(bus.busy), 32'd0);
    check_output("t4_stall", 32'(bus.stall), 32'd0);
    check_output("t4_done", 32'(bus.done), 32'd0);
    check_output("t4_result", bus.result, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    apply_stimulus(1'b1, OP_ADD, 32'd3, 32'd4, 1'b0);
    check_output("t4_add_stall", 32'(bus.stall), 32'd0);
    tick();
    apply_stimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
    check_output("t4_add_busy", 32'(bus.busy), 32'd0);

    // flush mid-RUN after a completed 0x2A
    run_op("t5_pre", OP_MUL, 32'd7, 32'd6, 32'h0000002A);
    apply_stimulus(1'b1, OP_MUL, 32'd100, 32'hFFFFFFFF, 1'b0);
    tick();
    apply_stimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
    repeat (4) tick();
    apply_stimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);
    check_output("t5_busy_flushcyc", 32'(bus.busy), 32'd1);
    tick();
    apply_stimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
    check_output("t5_busy", 32'(bus.busy), 32'd0);
    check_output("t5_stall", 32'(bus.stall), 32'd0);
    begin
      int done_seen;
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
        if (bus.done) done_seen++;
        tick();
        #1;
      end
      check_output("t5_no_done", 32'(done_seen), 32'd0);
    end
    check_output("t5_result_hold", bus.result, 32'h0000002A);
    apply_stimulus(1'b1, OP_MUL, 32'd2, 32'd2, 1'b1);
    check_output("t5_flush_start_stall", 32'(bus.stall), 32'd0);
    tick();
    apply_stimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
    check_output("t5_flush_start_busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
